// File: rtl/arinc708_tx_framer_if.sv
// Link between the ARINC 708 transmit framer and the line serializer.
// The framer offers words (valid/data); the serializer accepts them and reports line status.
interface arinc708_tx_framer_if;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;
  logic        tx_active;
  logic        tx_done;

  modport master (output tx_valid, tx_data, input tx_ready, tx_active, tx_done);
  modport slave  (input tx_valid, tx_data, output tx_ready, tx_active, tx_done);
endinterface

// File: rtl/arinc708_tx_framer.sv
// ARINC 708 transmit framer: show-ahead word FIFO feeding a serializer one full frame at a time,
// with sticky interrupt flags and a completed-frame counter.
//
// state     | meaning
// IDLE      | waiting for enable, no hold, idle line and a full frame queued
// SEND      | offering FIFO words to the serializer, counting accepted words
// WAIT_DONE | all frame words handed over, waiting for the line to finish shifting
module arinc708_tx_framer #(
  parameter int FIFO_DEPTH  = 512,
  parameter int FRAME_WORDS = 50,
  parameter int CNT_W       = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cfg_en,
  input  logic                        cfg_hold,
  input  logic [3:0]                  irq_mask,
  input  logic [3:0]                  irq_clear,
  input  logic [31:0]                 wr_data,
  input  logic                        wr_en,
  arinc708_tx_framer_if.master        tx,
  output logic [3:0]                  irq_flags,
  output logic                        irq,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]            frame_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = $clog2(FRAME_WORDS + 1);
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] FRAME_L = LW'(FRAME_WORDS);
  localparam logic [WW-1:0] LAST_W  = WW'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;

  state_t        state, state_nxt;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [LW-1:0] level;
  logic [WW-1:0] wcnt, wcnt_nxt;
  logic          en_meta, en_s;
  logic          valid_c, pop, wr_ok, wr_drop, abort, frame_done;
  logic [3:0]    flags, flag_set;
  logic [CNT_W-1:0] fcnt;

  always_comb begin
    state_nxt  = state;
    wcnt_nxt   = wcnt;
    valid_c    = 1'b0;
    abort      = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (en_s && !cfg_hold && !tx.tx_active && level >= FRAME_L) begin
          state_nxt = SEND;
          wcnt_nxt  = '0;
        end
      end
      SEND: begin
        if (!en_s) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          valid_c = (level != '0);
          if (valid_c && tx.tx_ready) begin
            wcnt_nxt = wcnt + 1'b1;
            if (wcnt == LAST_W) state_nxt = WAIT_DONE;
          end
        end
      end
      WAIT_DONE: begin
        if (!en_s) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (tx.tx_done) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A full FIFO still takes a word when the head leaves in the same cycle; the flush cycle takes nothing.
  assign pop      = valid_c && tx.tx_ready;
  assign wr_ok    = wr_en && !abort && ((level != DEPTH_L) || pop);
  assign wr_drop  = wr_en && !abort && !wr_ok;
  assign flag_set = {abort, frame_done && (level == '0), wr_drop, frame_done};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      wcnt    <= '0;
      en_meta <= 1'b0;
      en_s    <= 1'b0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level   <= '0;
      fcnt    <= '0;
      flags   <= '0;
    end else begin
      en_meta <= cfg_en;
      en_s    <= en_meta;
      state   <= state_nxt;
      wcnt    <= wcnt_nxt;
      if (abort) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        level  <= '0;
      end else begin
        if (pop)   rd_ptr <= rd_ptr + 1'b1;
        if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
        level <= level + LW'(wr_ok) - LW'(pop);
      end
      if (frame_done) fcnt <= fcnt + 1'b1;
      // Set wins over a same-cycle clear.
      flags <= (flags & ~irq_clear) | flag_set;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  assign tx.tx_valid = valid_c;
  assign tx.tx_data  = mem[rd_ptr];
  assign irq_flags   = flags;
  assign irq         = |(flags & irq_mask);
  assign fifo_level  = level;
  assign frame_count = fcnt;

endmodule

// File: tb/tb_arinc708_tx_framer.sv
// Directed-sequence bench for arinc708_tx_framer with random payloads checked against a
// queue model of the FIFO, a frame-level flag model and a modulo frame counter.
module tb_arinc708_tx_framer;
  localparam int DEPTH = 512;
  localparam int FW    = 50;
  localparam int CW    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_en, cfg_hold;
  logic [3:0]  irq_mask, irq_clear;
  logic [31:0] wr_data;
  logic        wr_en;
  logic [3:0]  irq_flags;
  logic        irq;
  logic [9:0]  fifo_level;
  logic [CW-1:0] frame_count;

  arinc708_tx_framer_if txi();

  arinc708_tx_framer #(.FIFO_DEPTH(DEPTH), .FRAME_WORDS(FW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .cfg_en(cfg_en), .cfg_hold(cfg_hold),
    .irq_mask(irq_mask), .irq_clear(irq_clear), .wr_data(wr_data), .wr_en(wr_en),
    .tx(txi), .irq_flags(irq_flags), .irq(irq), .fifo_level(fifo_level),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  logic [31:0] q[$];
  logic [3:0]  exp_flags;
  int          exp_fc;
  int          frame_pops, valid_cnt;
  bit          chk_level;
  int          n_checks, n_pass, n_fail;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // One clock: model the handshake and write seen just before the edge, then step past the edge.
  task automatic tick();
    bit pop;
    @(negedge clk);
    if (chk_level) check("fifo_level", 32'(fifo_level), 32'(q.size()));
    pop = txi.tx_valid && txi.tx_ready;
    if (txi.tx_valid) begin
      valid_cnt++;
      check("valid_nonempty", 32'(q.size() != 0), 32'd1);
    end
    if (pop) begin
      if (q.size() > 0) begin
        check("tx_data", txi.tx_data, q[0]);
        void'(q.pop_front());
      end
      frame_pops++;
    end
    if (wr_en) begin
      if (q.size() < DEPTH) q.push_back(wr_data);
      else exp_flags[1] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write_words(input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = $urandom;
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic clear_flags(input logic [3:0] m);
    irq_clear = m;
    tick();
    irq_clear = 4'h0;
    exp_flags = exp_flags & ~m;
    check("flags_clear", 32'(irq_flags), 32'(exp_flags));
  endtask

  task automatic run_frame(input bit clr0);
    int  n;
    bit  under;
    n = 0;
    while (frame_pops < FW && n < 3000) begin
      tick();
      n++;
    end
    check("frame_pops", frame_pops, FW);
    under = (q.size() == 0);
    txi.tx_done = 1'b1;
    if (clr0) irq_clear = 4'b0001;
    tick();
    txi.tx_done = 1'b0;
    irq_clear   = 4'h0;
    exp_flags[0] = 1'b1;
    if (under) exp_flags[2] = 1'b1;
    exp_fc     = (exp_fc + 1) % (1 << CW);
    frame_pops = 0;
    check("frame_count", 32'(frame_count), 32'(exp_fc));
    check("flags_frame", 32'(irq_flags), 32'(exp_flags));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n_checks = 0; n_pass = 0; n_fail = 0;
    exp_flags = 4'h0; exp_fc = 0; frame_pops = 0; valid_cnt = 0; chk_level = 1'b1;
    reset = 1'b0; cfg_en = 1'b0; cfg_hold = 1'b0; irq_mask = 4'hF; irq_clear = 4'h0;
    wr_data = 32'h0; wr_en = 1'b0;
    txi.tx_ready = 1'b1; txi.tx_active = 1'b0; txi.tx_done = 1'b0;

    #12;
    check("rst_valid", 32'(txi.tx_valid), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_fc", 32'(frame_count), 32'd0);
    check("rst_flags", 32'(irq_flags), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Partial frame waits; the 50th word starts it, then a full frame drains in order.
    cfg_en = 1'b1; irq_mask = 4'h0;
    write_words(FW - 1);
    valid_cnt = 0;
    repeat (5) tick();
    check("no_start_partial", valid_cnt, 0);
    write_words(1);
    n = 0;
    while (!txi.tx_valid && n < 3) begin tick(); n++; end
    check("start_within_3", 32'(txi.tx_valid), 32'd1);
    run_frame(1'b0);
    check("irq_masked_off", 32'(irq), 32'd0);
    irq_mask = 4'b0001; #1;
    check("irq_frame_done", 32'(irq), 32'd1);
    clear_flags(4'hF);

    // Fill under hold, overflow drops the extra word.
    cfg_hold = 1'b1;
    valid_cnt = 0;
    write_words(DEPTH);
    check("full_level", 32'(fifo_level), DEPTH);
    check("hold_no_valid", valid_cnt, 0);
    write_words(1);
    check("ovf_level", 32'(fifo_level), DEPTH);
    check("ovf_flags", 32'(irq_flags), 32'b0010);
    irq_mask = 4'b0001; #1;
    check("irq_ovf_masked", 32'(irq), 32'd0);
    irq_mask = 4'b0010; #1;
    check("irq_ovf", 32'(irq), 32'd1);
    clear_flags(4'hF);

    // Release hold; a write in the same cycle as a pop on a full FIFO is accepted.
    cfg_hold = 1'b0;
    n = 0;
    while (!txi.tx_valid && n < 5) begin tick(); n++; end
    check("send_after_hold", 32'(txi.tx_valid), 32'd1);
    write_words(1);
    check("full_pop_write_level", 32'(fifo_level), DEPTH);
    check("full_pop_write_flags", 32'(irq_flags), 32'(exp_flags));
    run_frame(1'b0);
    run_frame(1'b1);

    // Abort mid-frame by dropping the enable.
    n = 0;
    while (frame_pops < 20 && n < 200) begin tick(); n++; end
    check("pops_before_abort", frame_pops, 20);
    cfg_en = 1'b0; chk_level = 1'b0;
    repeat (4) tick();
    check("abort_level", 32'(fifo_level), 32'd0);
    check("abort_valid", 32'(txi.tx_valid), 32'd0);
    exp_flags[3] = 1'b1;
    check("abort_flags", 32'(irq_flags), 32'(exp_flags));
    check("abort_fc", 32'(frame_count), 32'(exp_fc));
    q.delete(); frame_pops = 0; chk_level = 1'b1;

    // Hold with two frames queued, then release: back-to-back frames, counter wraps.
    clear_flags(4'hF);
    cfg_en = 1'b1; cfg_hold = 1'b1;
    valid_cnt = 0;
    write_words(2 * FW);
    repeat (10) tick();
    check("hold_100_no_valid", valid_cnt, 0);
    cfg_hold = 1'b0;
    run_frame(1'b0);
    run_frame(1'b0);
    check("fc_wrapped", 32'(frame_count), 32'd1);

    // tx_done while idle changes nothing.
    clear_flags(4'hF);
    txi.tx_done = 1'b1;
    tick();
    txi.tx_done = 1'b0;
    tick();
    check("stray_done_fc", 32'(frame_count), 32'(exp_fc));
    check("stray_done_flags", 32'(irq_flags), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/arinc708_tx_framer.md
ARINC708_TX_FRAMER -- requirements
Module: arinc708_tx_framer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 512 (power of 2, 16..4096), meaning transmit FIFO depth in 32-bit words.
REQ-002 SHALL have parameter FRAME_WORDS, default 50, meaning words per ARINC 708 frame (1600 bits / 32); 1..FIFO_DEPTH.
REQ-003 SHALL have parameter CNT_W, default 16, meaning frame counter width.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 cfg_en  input  1  transmitter enable (level).
REQ-007 cfg_hold  input  1  CPU owns buffer; blocks frame start.
REQ-008 irq_mask  input  4  per-flag interrupt enable.
REQ-009 irq_clear  input  4  per-flag clear, one-cycle pulse per bit.
REQ-010 wr_data  input  32  word to enqueue.
REQ-011 wr_en  input  1  enqueue strobe, one word per cycle.
REQ-012 tx_valid  output  1  word offered to serializer.
REQ-013 tx_data  output  32  FIFO head word.
REQ-014 tx_ready  input  1  serializer accepts word.
REQ-015 tx_active  input  1  serializer busy on line.
REQ-016 tx_done  input  1  one-cycle pulse, frame fully shifted out.
REQ-017 irq_flags  output  4  sticky flags: [0] frame done, [1] overflow, [2] underrun-after-frame, [3] abort.
REQ-018 irq  output  1  OR of irq_flags & irq_mask.
REQ-019 fifo_level  output  log2(FIFO_DEPTH)+1  words stored.
REQ-020 frame_count  output  CNT_W  frames completed.

Function
REQ-021 FIFO SHALL be show-ahead: tx_data equals the oldest word whenever fifo_level>0.
REQ-022 Write SHALL be accepted when wr_en and (fifo_level<FIFO_DEPTH or a pop occurs same cycle); otherwise word dropped and flag[1] set.
REQ-023 Pop SHALL occur exactly on cycles with tx_valid and tx_ready; fifo_level updates next cycle (+1 write, -1 pop, 0 both).
REQ-024 cfg_en SHALL pass a 2-stage synchronizer; en_s denotes its output.
REQ-025 FSM states SHALL be IDLE, SEND, WAIT_DONE.
REQ-026 IDLE->SEND when en_s, !cfg_hold, !tx_active, fifo_level>=FRAME_WORDS; word counter cleared.
REQ-027 tx_valid SHALL be 1 only in SEND; never when fifo_level==0.
REQ-028 SEND: each accepted word increments word counter; acceptance of word FRAME_WORDS -> WAIT_DONE next cycle.
REQ-029 WAIT_DONE: on tx_done -> IDLE, frame_count+1 (wraps to 0 at 2^CNT_W), flag[0] set; flag[2] set if fifo_level==0 after that frame's pops.
REQ-030 Frame start SHALL never begin with fewer than FRAME_WORDS words queued; partial frames wait in IDLE.
REQ-031 en_s low in SEND or WAIT_DONE SHALL abort: -> IDLE next cycle, FIFO flushed (level 0), flag[3] set, frame_count unchanged.
REQ-032 cfg_hold SHALL only gate IDLE->SEND; frame in progress continues.
REQ-033 Flag set and clear in same cycle SHALL leave flag set.
REQ-034 irq SHALL be combinational from irq_flags and irq_mask.
REQ-035 tx_done outside WAIT_DONE SHALL be ignored.
REQ-036 Write during abort/flush cycle SHALL be discarded.

Reset
REQ-037 reset low SHALL asynchronously force: state IDLE, tx_valid 0, fifo_level 0, frame_count 0, irq_flags 0, irq 0, synchronizer 0, word counter 0.
REQ-038 After reset release, first frame start SHALL need at least 2 cycles of cfg_en high.

Verification
REQ-039 Write 50 words, cfg_en=1, tx_ready=1, tx_done pulse after 50th pop -> 50 pops in order, frame_count=1, flag[0]=1, flag[2]=1.
REQ-040 Write 49 words, cfg_en=1 -> tx_valid stays 0; 50th write -> SEND entered within 3 cycles.
REQ-041 Fill 512 words, 513th wr_en -> dropped, flag[1]=1, fifo_level=512; same with simultaneous pop -> accepted, no flag.
REQ-042 Drop cfg_en after 20 pops -> state IDLE, fifo_level 0, flag[3]=1, frame_count unchanged.
REQ-043 irq_mask=4'b0001, flag[1] set only -> irq 0; flag[0] set -> irq 1; irq_clear[0] same cycle as new tx_done -> flag[0] stays 1.
REQ-044 cfg_hold=1 with 100 words queued -> no start; release -> two back-to-back frames, frame_count=2.
